// File: rtl/mult_share_sched.sv
// Round-robin scheduler that time-shares one add-shift multiplier datapath
// between two requesters and sequences its Clr_Ld/Add/Sub/Shift strobes.
module mult_share_sched #(
  parameter int ITER = 8
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic [1:0] Req,
  input  logic       M,
  output logic [1:0] Gnt,
  output logic [1:0] Done,
  output logic       Busy,
  output logic       Clr_Ld,
  output logic       Add,
  output logic       Sub,
  output logic       Shift,
  output logic [2:0] currentState
);

  localparam int CW = (ITER > 1) ? $clog2(ITER) : 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    ADD   = 3'd2,
    SHIFT = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t        state;
  state_t        next_state;
  logic [CW-1:0] cnt;
  logic [1:0]    gnt;
  logic          last;
  logic          win;
  logic          cnt_last;

  // With both requesting, the one not served last time wins.
  assign win      = (Req == 2'b11) ? ~last : Req[1];
  assign cnt_last = (cnt == CW'(ITER - 1));

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state <= IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state = IDLE;
    case (state)
      IDLE:    next_state = (|Req) ? LOAD : IDLE;
      LOAD:    next_state = ADD;
      ADD:     next_state = SHIFT;
      SHIFT:   next_state = cnt_last ? DONE : ADD;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Grant is latched on the IDLE->LOAD edge and held until DONE ends.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      gnt  <= 2'b00;
      last <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (|Req) begin
            gnt  <= win ? 2'b10 : 2'b01;
            last <= win;
          end else begin
            gnt  <= 2'b00;
          end
        end
        LOAD, ADD, SHIFT: gnt <= gnt;
        default:          gnt <= 2'b00;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n)              cnt <= '0;
    else if (state == LOAD)    cnt <= '0;
    else if (state == SHIFT)   cnt <= cnt + 1'b1;
  end

  always_comb begin
    Busy   = 1'b1;
    Clr_Ld = 1'b0;
    Add    = 1'b0;
    Sub    = 1'b0;
    Shift  = 1'b0;
    Done   = 2'b00;
    case (state)
      IDLE:  Busy = 1'b0;
      LOAD:  Clr_Ld = 1'b1;
      ADD: begin
        // The final iteration subtracts to correct the sign of the multiplier.
        if (M) begin
          if (cnt_last) Sub = 1'b1;
          else          Add = 1'b1;
        end
      end
      SHIFT: Shift = 1'b1;
      DONE:  Done = gnt;
      default: Busy = 1'b0;
    endcase
  end

  assign Gnt          = gnt;
  assign currentState = state;

endmodule

// File: tb/tb_mult_share_sched.sv
// Scoreboard bench for mult_share_sched: per-cycle expected output words are
// queued when a request is issued and popped against the DUT every cycle.
module tb_mult_share_sched;

  logic       Clk;
  logic       Reset_n;
  logic [1:0] Req;
  logic       M;
  logic [1:0] Gnt;
  logic [1:0] Done;
  logic       Busy;
  logic       Clr_Ld;
  logic       Add;
  logic       Sub;
  logic       Shift;
  logic [2:0] currentState;

  int checks   = 0;
  int failures = 0;

  logic [11:0] exp_q[$];
  logic        last_m;
  logic [7:0]  b_src0;
  logic [7:0]  b_src1;
  logic [7:0]  b_sh;

  mult_share_sched #(.ITER(8)) dut (
    .Clk          (Clk),
    .Reset_n      (Reset_n),
    .Req          (Req),
    .M            (M),
    .Gnt          (Gnt),
    .Done         (Done),
    .Busy         (Busy),
    .Clr_Ld       (Clr_Ld),
    .Add          (Add),
    .Sub          (Sub),
    .Shift        (Shift),
    .currentState (currentState)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Stand-in for the datapath B register: M is its LSB.
  always @(posedge Clk) begin
    if (Clr_Ld)     b_sh <= Gnt[1] ? b_src1 : b_src0;
    else if (Shift) b_sh <= b_sh >> 1;
  end
  assign M = b_sh[0];

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, expv, $time);
    end
  endtask

  function automatic logic [11:0] rec(input logic [2:0] st, input logic [1:0] g, input logic [1:0] d,
                                      input logic busy, input logic clr, input logic add,
                                      input logic sub, input logic sh);
    return {st, g, d, busy, clr, add, sub, sh};
  endfunction

  task automatic pushIdle(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(rec(3'd0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
  endtask

  // Called #1 into an IDLE cycle; queues that cycle plus LOAD..DONE.
  task automatic applyStimulus(input logic [1:0] req, input logic [7:0] b0, input logic [7:0] b1);
    logic       w;
    logic [1:0] g;
    logic [7:0] b;
    Req    = req;
    b_src0 = b0;
    b_src1 = b1;
    w = (req == 2'b11) ? ~last_m : req[1];
    g = w ? 2'b10 : 2'b01;
    b = w ? b1 : b0;
    last_m = w;
    pushIdle(1);
    exp_q.push_back(rec(3'd1, g, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0));
    for (int k = 0; k < 8; k++) begin
      exp_q.push_back(rec(3'd2, g, 2'b00, 1'b1, 1'b0, b[k] && (k < 7), b[k] && (k == 7), 1'b0));
      exp_q.push_back(rec(3'd3, g, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1));
    end
    exp_q.push_back(rec(3'd4, g, g, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
  endtask

  task automatic waitCycles(input int n);
    repeat (n) begin
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_state"}, 32'(currentState), 32'd0);
    checkOutput({tag, "_gnt"},   32'(Gnt),          32'd0);
    checkOutput({tag, "_done"},  32'(Done),         32'd0);
    checkOutput({tag, "_busy"},  32'(Busy),         32'd0);
    checkOutput({tag, "_strb"},  32'({Clr_Ld, Add, Sub, Shift}), 32'd0);
  endtask

  always @(negedge Clk) begin
    if (exp_q.size() > 0) begin
      logic [11:0] e;
      e = exp_q.pop_front();
      checkOutput("seq", 32'({currentState, Gnt, Done, Busy, Clr_Ld, Add, Sub, Shift}), 32'(e));
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time 0x%0h exceeded limit 0x%0h", $time, 100000);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    Reset_n = 1'b0;
    Req     = 2'b11;
    b_src0  = 8'h00;
    b_src1  = 8'h00;
    last_m  = 1'b1;
    waitCycles(3);
    checkAllZero("rst");

    // Release with both requesting: 0 wins first, then strict alternation.
    Reset_n = 1'b1;
    applyStimulus(2'b11, 8'h5A, 8'hC3);
    waitCycles(18);
    Req = 2'b11;
    waitCycles(1);
    applyStimulus(2'b11, 8'h5A, 8'hC3);
    waitCycles(18);
    Req = 2'b11;
    waitCycles(1);
    applyStimulus(2'b11, 8'h5A, 8'hC3);
    waitCycles(18);
    Req = 2'b00;
    waitCycles(1);
    pushIdle(2);
    waitCycles(2);

    applyStimulus(2'b01, 8'h05, 8'h00);
    waitCycles(18);
    Req = 2'b00;
    waitCycles(1);
    pushIdle(1);
    waitCycles(1);

    applyStimulus(2'b10, 8'h00, 8'h80);
    waitCycles(18);
    Req = 2'b00;
    waitCycles(1);
    pushIdle(1);
    waitCycles(1);

    // Abort during the SHIFT of iteration 4, checked before any clock edge.
    applyStimulus(2'b01, 8'hFF, 8'h00);
    waitCycles(11);
    #2;
    exp_q.delete();
    Reset_n = 1'b0;
    #1;
    checkAllZero("async");
    waitCycles(1);
    Reset_n = 1'b1;
    last_m  = 1'b1;
    applyStimulus(2'b01, 8'hFF, 8'h00);
    waitCycles(18);
    Req = 2'b00;
    waitCycles(1);
    pushIdle(1);
    waitCycles(1);

    // Requester 0 drops mid-run; its job still finishes, then 1 wins contention.
    applyStimulus(2'b01, 8'h3C, 8'h00);
    waitCycles(8);
    Req = 2'b00;
    waitCycles(10);
    waitCycles(1);
    applyStimulus(2'b11, 8'h3C, 8'h81);
    waitCycles(18);
    Req = 2'b00;
    waitCycles(1);
    pushIdle(1);
    waitCycles(2);

    checkOutput("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
